booth_seq_multiplier: RTL and testbench
=======================================

BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled in IDLE only.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a  input  N  multiplicand; sampled with start.
REQ-007 SHALL have port b  input  N  multiplier; sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (state != IDLE).
REQ-009 SHALL have port done  output  1  single-cycle pulse marking product valid.
REQ-010 SHALL have port product  output  2N  registered result.

Function
REQ-011 SHALL implement radix-2 Booth recoding iteratively: one add/sub/none decision plus arithmetic right shift per CALC cycle.
REQ-012 SHALL internally extend a and b to N+1 bits: sign-extend when is_signed=1, zero-extend when is_signed=0.
REQ-013 SHALL use accumulator/shift datapath of 2N+3 bits (N+1 high, N+1 multiplier, 1 Booth q-1 bit); no other widths observable.
REQ-014 SHALL have FSM states IDLE, CALC, DONE only.
REQ-015 IDLE: start=1 at rising edge -> capture a, b, is_signed, clear accumulator and q-1, load iteration counter 0, go to CALC.
REQ-016 CALC: each edge performs one Booth step and increments counter; after the (N+1)th step -> DONE.
REQ-017 DONE: lasts exactly one cycle, done=1, then -> IDLE unconditionally.
REQ-018 Latency: start high in cycle t -> done high in cycle t+N+2 exactly; busy high cycles t+1..t+N+2.
REQ-019 product SHALL load the low 2N bits of the final result on the edge entering DONE and hold it until the next such edge.
REQ-020 start while busy=1 (CALC or DONE) SHALL be ignored, with no effect on operands, mode or result.
REQ-021 start held continuously SHALL begin a new operation on the edge following DONE (cycle t+N+3 sample), giving back-to-back ops every N+3 cycles.
REQ-022 Changes on a, b, is_signed after capture SHALL not affect the running operation.
REQ-023 Signed result SHALL equal exact two's-complement product of a and b; unsigned result exact unsigned product; both fit 2N bits (incl. -2^(N-1) * -2^(N-1)).
REQ-024 done SHALL never be high for more than one consecutive cycle.

Reset
REQ-025 reset_n=0 SHALL immediately (asynchronously) force state=IDLE, busy=0, done=0, product=0, counter=0, internal registers=0.
REQ-026 Reset asserted mid-CALC SHALL abandon the operation; no done pulse for it after release; product remains 0.
REQ-027 After reset_n deasserts, first start SHALL be accepted on the first rising edge where reset_n=1 and start=1.

Verification
REQ-028 N=8, is_signed=1, a=0xFD (-3), b=0x05, start 1 cycle -> done in cycle t+10, product=0xFFF1.
REQ-029 N=8, is_signed=0, a=0xFF, b=0xFF -> product=0xFE01; same operands is_signed=1 -> product=0x0001.
REQ-030 N=8, is_signed=1, a=0x80, b=0x80 -> product=0x4000; a=0x80, b=0x7F -> product=0xC080.
REQ-031 N=8, start a=0x02,b=0x03, then pulse start with a=0x10,b=0x10 in cycle t+4 -> ignored; product=0x0006, single done pulse.
REQ-032 N=8, start with a=0x0C,b=0x0A, drop reset_n in cycle t+5 for 2 cycles -> busy=0, done=0, product=0x0000 through and after release until new start.
REQ-033 N=16, random 1000 signed and unsigned pairs with start held high -> every product matches reference model, done every 19 cycles.

Source files
------------

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier.
// Operands are extended to N+1 bits so the same datapath serves signed and
// unsigned modes. One Booth step (add/sub/none plus arithmetic right shift)
// runs per CALC cycle. N+1 steps are needed, and the result is registered on
// the edge that enters DONE.
module booth_seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int W  = N + 1;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] LAST_STEP = CW'(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [W-1:0]     acc_q;      // high half of the shift register
  logic [W-1:0]     mcand_q;    // extended multiplicand
  logic [W-1:0]     mplier_q;   // multiplier, shifted out LSB first
  logic             qm1_q;      // Booth q-1 bit
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic [2*N-1:0]   product_q;

  logic [W-1:0]     a_ext;
  logic [W-1:0]     b_ext;
  logic [W-1:0]     acc_sum;
  logic [W-1:0]     acc_d;
  logic [W-1:0]     mplier_d;
  logic             qm1_d;
  logic [2*N-1:0]   product_d;

  // Operand extension: sign bit replicated only in signed mode.
  assign a_ext = {is_signed & a[N-1], a};
  assign b_ext = {is_signed & b[N-1], b};

  // Booth decision on {q0, q-1}: 01 adds the multiplicand, 10 subtracts it.
  always_comb begin
    acc_sum = acc_q;
    case ({mplier_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + mcand_q;
      2'b10:   acc_sum = acc_q - mcand_q;
      default: acc_sum = acc_q;
    endcase
  end

  // Arithmetic right shift of {acc, multiplier, q-1} by one position.
  assign acc_d     = {acc_sum[W-1], acc_sum[W-1:1]};
  assign mplier_d  = {acc_sum[0], mplier_q[W-1:1]};
  assign qm1_d     = mplier_q[0];
  // Low 2N bits of the shifted {acc, multiplier} pair are the product.
  assign product_d = {acc_d[N-2:0], mplier_d};

  // Control FSM and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= a_ext;
            mplier_q <= b_ext;
            acc_q    <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          qm1_q    <= qm1_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            product_q <= product_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier. An N=8 instance runs directed
// vectors and the reset and ignored-start scenarios. An N=16 instance runs
// back-to-back operations with start held high.
module tb_booth_seq_multiplier;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start8, sgn8, start16, sgn16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, busy16, done16;
  logic [15:0] product8;
  logic [31:0] product16;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t q8[$];
  exp_t q16[$];

  booth_seq_multiplier #(.N(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .is_signed(sgn8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
  );

  booth_seq_multiplier #(.N(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .is_signed(sgn16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .product(product16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; optionally record the expected result.
  task automatic pulse8(input logic sg, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] ex, input bit push);
    start8 = 1'b1; sgn8 = sg; a8 = av; b8 = bv;
    if (push) q8.push_back('{prod: {16'h0, ex}, cyc: cyc + 10});
    wait_cycles(1);
    start8 = 1'b0;
  endtask

  function automatic logic [31:0] ref16(input logic s, input logic [15:0] x, input logic [15:0] y);
    logic signed [31:0] sx, sy;
    if (s) begin
      sx = 32'($signed(x));
      sy = 32'($signed(y));
      return sx * sy;
    end
    return {16'h0, x} * {16'h0, y};
  endfunction

  // Monitor for the N=8 instance.
  initial begin
    exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (done8) begin
          chk("dut8_done_single", {31'h0, prev}, 32'h0);
          if (q8.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL dut8_unexpected_done actual=product %h required=no done (cycle %0d)", product8, cyc);
          end else begin
            e = q8.pop_front();
            $display("dut8 txn cycle=%0d product=%h expected=%h", cyc, product8, e.prod[15:0]);
            chk("dut8_product", {16'h0, product8}, e.prod);
            chk("dut8_latency", cyc, e.cyc);
          end
        end else if (q8.size() > 0 && cyc > q8[0].cyc) begin
          e = q8.pop_front();
          n_cmp++; n_err++;
          $display("FAIL dut8_missing_done actual=none required=done at cycle %0d", e.cyc);
        end
      end
      prev = done8;
    end
  end

  // Monitor for the N=16 instance.
  initial begin
    exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (done16) begin
          chk("dut16_done_single", {31'h0, prev}, 32'h0);
          if (q16.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL dut16_unexpected_done actual=product %h required=no done (cycle %0d)", product16, cyc);
          end else begin
            e = q16.pop_front();
            $display("dut16 txn cycle=%0d product=%h expected=%h", cyc, product16, e.prod);
            chk("dut16_product", product16, e.prod);
            chk("dut16_latency", cyc, e.cyc);
          end
        end else if (q16.size() > 0 && cyc > q16[0].cyc) begin
          e = q16.pop_front();
          n_cmp++; n_err++;
          $display("FAIL dut16_missing_done actual=none required=done at cycle %0d", e.cyc);
        end
      end
      prev = done16;
    end
  end

  // Stimulus.
  initial begin
    logic [15:0] va [4] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h8000};
    logic [15:0] vb [4] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h7FFF};
    logic        vs [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] ve [4] = '{32'h4000_0000, 32'h0000_0001, 32'hFFFE_0001, 32'hC000_8000};
    logic        s;
    logic [15:0] x, y;
    logic [31:0] ex;

    reset_n = 1'b0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    #12;
    chk("reset_busy8", {31'h0, busy8}, 32'h0);
    chk("reset_done8", {31'h0, done8}, 32'h0);
    chk("reset_product8", {16'h0, product8}, 32'h0);
    chk("reset_busy16", {31'h0, busy16}, 32'h0);
    chk("reset_product16", product16, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_cycles(1);

    // Directed N=8 vectors.
    pulse8(1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b1); wait_cycles(11);
    pulse8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1); wait_cycles(11);
    pulse8(1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b1); wait_cycles(11);
    pulse8(1'b1, 8'h80, 8'h80, 16'h4000, 1'b1); wait_cycles(11);
    pulse8(1'b1, 8'h80, 8'h7F, 16'hC080, 1'b1); wait_cycles(11);
    pulse8(1'b0, 8'h0C, 8'h0A, 16'h0078, 1'b1); wait_cycles(11);

    // A start while busy must be ignored, and so must operand changes.
    pulse8(1'b0, 8'h02, 8'h03, 16'h0006, 1'b1);
    wait_cycles(3);
    pulse8(1'b0, 8'h10, 8'h10, 16'h0000, 1'b0);
    wait_cycles(1);
    a8 = 8'hFF; b8 = 8'hFF; sgn8 = 1'b1;
    wait_cycles(12);

    // Reset in the middle of CALC abandons the operation.
    pulse8(1'b0, 8'h0C, 8'h0A, 16'h0000, 1'b0);
    wait_cycles(4);
    reset_n = 1'b0;
    #1;
    chk("midreset_busy8", {31'h0, busy8}, 32'h0);
    chk("midreset_done8", {31'h0, done8}, 32'h0);
    chk("midreset_product8", {16'h0, product8}, 32'h0);
    wait_cycles(2);
    reset_n = 1'b1;
    repeat (14) begin
      @(negedge clk);
      chk("postreset_busy8", {31'h0, busy8}, 32'h0);
      chk("postreset_done8", {31'h0, done8}, 32'h0);
      chk("postreset_product8", {16'h0, product8}, 32'h0);
    end
    @(posedge clk); #1;
    pulse8(1'b1, 8'h0C, 8'hF6, 16'hFF88, 1'b1); wait_cycles(11);

    // Back-to-back N=16 operations with start held high.
    start16 = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (k < 4) begin
        s = vs[k]; x = va[k]; y = vb[k]; ex = ve[k];
      end else begin
        s = 1'($urandom_range(0, 1));
        x = 16'($urandom);
        y = 16'($urandom);
        ex = ref16(s, x, y);
      end
      sgn16 = s; a16 = x; b16 = y;
      q16.push_back('{prod: ex, cyc: cyc + 18});
      wait_cycles(5);
      a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = ~s;
      wait_cycles(14);
    end
    start16 = 1'b0;
    wait_cycles(25);

    chk("dut8_queue_empty", q8.size(), 32'h0);
    chk("dut16_queue_empty", q16.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
